// File: rtl/sdbp_frame_reader_if.sv
// Frame RAM read port between the SDBP frame reader (master) and the frame RAM (slave).
// rd_data must be valid exactly one clk after rd_en_o is sampled high.
interface sdbp_frame_reader_if #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 16
) ();

    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [WORD_W-1:0] rd_data;

    modport master (
        output rd_en_o,
        output rd_addr_o,
        input  rd_data
    );

    modport slave (
        input  rd_en_o,
        input  rd_addr_o,
        output rd_data
    );

endinterface

// File: rtl/sdbp_frame_reader.sv
// SDBP frame reader: on each sdbp_flag rising edge, fetches NUM_LEDS grey words from the frame RAM,
// shifts them MSB-first to the MiniLED driver chain on sdo_o/sclk_o, then pulses le_o to latch.
module sdbp_frame_reader #(
    parameter int NUM_LEDS  = 360,
    parameter int WORD_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int LE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sdbp_flag,
    sdbp_frame_reader_if.master ram,
    output logic                sdo_o,
    output logic                sclk_o,
    output logic                le_o,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic                overrun_o
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int LE_W  = (LE_CYCLES > 1) ? $clog2(LE_CYCLES + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [LE_W-1:0]   LE_LAST   = LE_W'(LE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        LATCH,
        DONE
    } state_e;

    state_e            state_q;
    logic              flag_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [WORD_W-1:0] shreg_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              phase_q;
    logic [LE_W-1:0]   le_cnt_q;

    logic rd_en_q;
    logic sdo_q;
    logic sclk_q;
    logic le_q;
    logic busy_q;
    logic done_q;
    logic overrun_q;

    logic start;

    assign start = sdbp_flag & ~flag_q;

    assign ram.rd_en_o   = rd_en_q;
    assign ram.rd_addr_o = word_idx_q;
    assign sdo_o         = sdo_q;
    assign sclk_o        = sclk_q;
    assign le_o          = le_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = done_q;
    assign overrun_o     = overrun_q;

    // NOTE: every register here is updated with <= so all state moves together on the clock
    // edge; blocking assignments would let later statements see half-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            flag_q     <= 1'b0;
            word_idx_q <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            phase_q    <= 1'b0;
            le_cnt_q   <= '0;
            rd_en_q    <= 1'b0;
            sdo_q      <= 1'b0;
            sclk_q     <= 1'b0;
            le_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            flag_q <= sdbp_flag;

            // A request that arrives in any non-idle state (DONE included) is dropped but remembered.
            if (start && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= FETCH;
                        busy_q     <= 1'b1;
                        word_idx_q <= '0;
                        rd_en_q    <= 1'b1;
                    end
                end

                FETCH: begin
                    rd_en_q <= 1'b0;
                    state_q <= LOAD;
                end

                LOAD: begin
                    shreg_q   <= ram.rd_data;
                    bit_cnt_q <= LAST_BIT;
                    phase_q   <= 1'b0;
                    sdo_q     <= ram.rd_data[WORD_W-1];
                    sclk_q    <= 1'b0;
                    state_q   <= SHIFT;
                end

                SHIFT: begin
                    if (!phase_q) begin
                        sclk_q  <= 1'b1;
                        phase_q <= 1'b1;
                    end else begin
                        shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
                        sclk_q  <= 1'b0;
                        phase_q <= 1'b0;
                        if (bit_cnt_q == '0) begin
                            sdo_q <= 1'b0;
                            if (word_idx_q == LAST_ADDR) begin
                                state_q  <= LATCH;
                                le_q     <= 1'b1;
                                le_cnt_q <= '0;
                            end else begin
                                word_idx_q <= word_idx_q + ADDR_W'(1);
                                rd_en_q    <= 1'b1;
                                state_q    <= FETCH;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q - BIT_W'(1);
                            sdo_q     <= shreg_q[WORD_W-2];
                        end
                    end
                end

                LATCH: begin
                    if (le_cnt_q == LE_LAST) begin
                        le_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        le_cnt_q <= le_cnt_q + LE_W'(1);
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdbp_frame_reader.sv
// Directed bench for sdbp_frame_reader: RAM model plus per-scenario tasks with hand-computed
// expectations for ordering, timing, overrun, held flag, mid-frame reset and constant frames.
module tb_sdbp_frame_reader;

    localparam int NUM_LEDS  = 360;
    localparam int WORD_W    = 16;
    localparam int ADDR_W    = 10;
    localparam int LE_CYCLES = 4;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic sdbp_flag = 1'b0;
    logic sdo_o, sclk_o, le_o, busy_o, frame_done_o, overrun_o;

    sdbp_frame_reader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) ram ();

    sdbp_frame_reader #(
        .NUM_LEDS (NUM_LEDS),
        .WORD_W   (WORD_W),
        .ADDR_W   (ADDR_W),
        .LE_CYCLES(LE_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sdbp_flag   (sdbp_flag),
        .ram         (ram),
        .sdo_o       (sdo_o),
        .sclk_o      (sclk_o),
        .le_o        (le_o),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o),
        .overrun_o   (overrun_o)
    );

    always #20 clk = ~clk;

    // RAM contents: 0 = {a[7:0],a[7:0]}, 1 = all ones, 2 = all zeros. Junk when not reading.
    int mem_mode = 0;

    function automatic logic [WORD_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        case (mem_mode)
            1:       return 16'hFFFF;
            2:       return 16'h0000;
            default: return {a[7:0], a[7:0]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram.rd_en_o) ram.rd_data <= ram_word(ram.rd_addr_o);
        else             ram.rd_data <= WORD_W'($urandom);
    end

    int checks = 0;
    int errors = 0;

    int cyc, n_rd, first_rd_cyc, exp_addr, addr_err, gap_err;
    int n_rise, last_rise_cyc, period_err, hold_err, bit_pos, word_n;
    int n_le_cyc, n_le_pulse, le_first_cyc, idle_err;
    int n_done, done_cyc, first_busy_cyc, busy_fall_cyc, n_sdo_hi;
    logic prev_sclk, prev_sdo, prev_le, prev_busy;
    logic [WORD_W-1:0] cur_word;
    logic [WORD_W-1:0] capt [NUM_LEDS];

    task automatic clear_stats();
        cyc = 0; n_rd = 0; first_rd_cyc = -1; exp_addr = 0; addr_err = 0; gap_err = 0;
        n_rise = 0; last_rise_cyc = 0; period_err = 0; hold_err = 0; bit_pos = 0; word_n = 0;
        n_le_cyc = 0; n_le_pulse = 0; le_first_cyc = -1; idle_err = 0;
        n_done = 0; done_cyc = -1; first_busy_cyc = -1; busy_fall_cyc = -1; n_sdo_hi = 0;
        cur_word = '0;
        for (int i = 0; i < NUM_LEDS; i++) capt[i] = 'x;
        prev_sclk = sclk_o; prev_sdo = sdo_o; prev_le = le_o; prev_busy = busy_o;
    endtask

    // Steps n cycles, observing the DUT at each falling edge.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (ram.rd_en_o === 1'b1) begin
                n_rd++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (ram.rd_addr_o !== ADDR_W'(exp_addr)) addr_err++;
                exp_addr++;
                if (sclk_o !== 1'b0 || sdo_o !== 1'b0) gap_err++;
            end
            if (sclk_o === 1'b1 && prev_sclk === 1'b0) begin
                n_rise++;
                if (sdo_o !== prev_sdo) hold_err++;
                if (bit_pos != 0 && (cyc - last_rise_cyc) != 2) period_err++;
                last_rise_cyc = cyc;
                cur_word = {cur_word[WORD_W-2:0], sdo_o};
                bit_pos++;
                if (bit_pos == WORD_W) begin
                    if (word_n < NUM_LEDS) capt[word_n] = cur_word;
                    word_n++;
                    bit_pos = 0;
                end
            end
            if (le_o === 1'b1) begin
                n_le_cyc++;
                if (sclk_o !== 1'b0 || sdo_o !== 1'b0) idle_err++;
                if (prev_le !== 1'b1) begin
                    n_le_pulse++;
                    if (le_first_cyc < 0) le_first_cyc = cyc;
                end
            end
            if (frame_done_o === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            if (busy_o === 1'b1 && first_busy_cyc < 0) first_busy_cyc = cyc;
            if (busy_o === 1'b0 && prev_busy === 1'b1) busy_fall_cyc = cyc;
            if (sdo_o === 1'b1) n_sdo_hi++;
            prev_sclk = sclk_o; prev_sdo = sdo_o; prev_le = le_o; prev_busy = busy_o;
        end
    endtask

    // Runs until two cycles past frame_done_o, or gives up after max_cyc cycles.
    task automatic run_until_done(input int max_cyc);
        int k = 0;
        while (k < max_cyc && !(n_done > 0 && cyc >= done_cyc + 2)) begin
            run_cycles(1);
            k++;
        end
    endtask

    // Raises sdbp_flag just after a falling edge; that edge is cycle 0 of the new window.
    task automatic start_frame();
        @(negedge clk);
        clear_stats();
        sdbp_flag = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sdbp_flag = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ram.rd_en_o !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", ram.rd_en_o); end
        checks++; if (ram.rd_addr_o !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", ram.rd_addr_o); end
        checks++; if (sdo_o !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b expected 0", sdo_o); end
        checks++; if (sclk_o !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk_o); end
        checks++; if (le_o !== 1'b0) begin errors++; $display("FAIL reset_le: got %b expected 0", le_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", frame_done_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
        rst_n = 1'b1;
        clear_stats();
        run_cycles(4);
        checks++; if (n_rd !== 0 || first_busy_cyc !== -1) begin errors++; $display("FAIL idle_no_start: got rd=%0d busy_at=%0d expected 0/-1", n_rd, first_busy_cyc); end
    endtask

    task automatic test_frame();
        int bad = 0;
        mem_mode = 0;
        start_frame();
        run_cycles(29);
        sdbp_flag = 1'b0;
        run_until_done(12400);
        for (int a = 0; a < NUM_LEDS; a++) if (capt[a] !== {a[7:0], a[7:0]}) bad++;
        checks++; if (first_rd_cyc !== 1) begin errors++; $display("FAIL rd_latency: got %0d expected 1", first_rd_cyc); end
        checks++; if (first_busy_cyc !== 1) begin errors++; $display("FAIL busy_rise: got %0d expected 1", first_busy_cyc); end
        checks++; if (n_rd !== 360 || addr_err !== 0) begin errors++; $display("FAIL addr_seq: got reads=%0d bad=%0d expected 360/0", n_rd, addr_err); end
        checks++; if (gap_err !== 0) begin errors++; $display("FAIL fetch_gap_idle: got %0d expected 0", gap_err); end
        checks++; if (n_rise !== 5760) begin errors++; $display("FAIL sclk_rises: got %0d expected 5760", n_rise); end
        checks++; if (capt[0] !== 16'h0000) begin errors++; $display("FAIL word0: got %h expected 0000", capt[0]); end
        checks++; if (capt[1] !== 16'h0101) begin errors++; $display("FAIL word1: got %h expected 0101", capt[1]); end
        checks++; if (capt[359] !== 16'h6767) begin errors++; $display("FAIL word359: got %h expected 6767", capt[359]); end
        checks++; if (bad !== 0 || word_n !== 360) begin errors++; $display("FAIL frame_words: got bad=%0d words=%0d expected 0/360", bad, word_n); end
        checks++; if (period_err !== 0 || hold_err !== 0) begin errors++; $display("FAIL sclk_timing: got period_err=%0d hold_err=%0d expected 0/0", period_err, hold_err); end
        checks++; if (le_first_cyc - first_rd_cyc !== 12240) begin errors++; $display("FAIL le_start: got %0d expected 12240", le_first_cyc - first_rd_cyc); end
        checks++; if (n_le_cyc !== 4 || n_le_pulse !== 1) begin errors++; $display("FAIL le_width: got cycles=%0d pulses=%0d expected 4/1", n_le_cyc, n_le_pulse); end
        checks++; if (idle_err !== 0) begin errors++; $display("FAIL latch_lines_low: got %0d expected 0", idle_err); end
        checks++; if (n_done !== 1 || done_cyc !== 12245) begin errors++; $display("FAIL frame_done: got n=%0d at=%0d expected 1/12245", n_done, done_cyc); end
        checks++; if (busy_fall_cyc !== 12246) begin errors++; $display("FAIL busy_fall: got %0d expected 12246", busy_fall_cyc); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL no_overrun: got %b expected 0", overrun_o); end
    endtask

    task automatic test_overrun();
        mem_mode = 0;
        start_frame();
        run_cycles(29);
        sdbp_flag = 1'b0;
        run_cycles(3376);
        checks++; if (overrun_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL pre_overrun: got ovr=%b busy=%b expected 0/1", overrun_o, busy_o); end
        sdbp_flag = 1'b1;
        run_cycles(2);
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun_o); end
        run_until_done(12400);
        checks++; if (n_rd !== 360 || addr_err !== 0) begin errors++; $display("FAIL overrun_addr_seq: got reads=%0d bad=%0d expected 360/0", n_rd, addr_err); end
        checks++; if (n_le_pulse !== 1 || le_first_cyc !== 12241 || n_done !== 1) begin errors++; $display("FAIL overrun_no_restart: got le=%0d at=%0d done=%0d expected 1/12241/1", n_le_pulse, le_first_cyc, n_done); end
        sdbp_flag = 1'b0;
        run_cycles(4);
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun_o); end
    endtask

    task automatic test_held_flag();
        mem_mode = 0;
        start_frame();
        run_cycles(20000);
        checks++; if (n_done !== 1 || n_le_pulse !== 1) begin errors++; $display("FAIL held_one_frame: got done=%0d le=%0d expected 1/1", n_done, n_le_pulse); end
        checks++; if (n_rd !== 360 || n_rise !== 5760) begin errors++; $display("FAIL held_counts: got reads=%0d rises=%0d expected 360/5760", n_rd, n_rise); end
        checks++; if (busy_o !== 1'b0 || overrun_o !== 1'b1) begin errors++; $display("FAIL held_end_state: got busy=%b ovr=%b expected 0/1", busy_o, overrun_o); end
        sdbp_flag = 1'b0;
        run_cycles(2);
    endtask

    task automatic test_reset_mid_frame();
        mem_mode = 0;
        start_frame();
        run_cycles(29);
        sdbp_flag = 1'b0;
        run_cycles(6790);
        // Word 200 = C8C8; its bit 7 is 1 and is on sdo_o in this phase-0 cycle.
        checks++; if (sdo_o !== 1'b1 || sclk_o !== 1'b0 || ram.rd_addr_o !== 10'd200) begin errors++; $display("FAIL pre_reset_pos: got sdo=%b sclk=%b addr=%0d expected 1/0/200", sdo_o, sclk_o, ram.rd_addr_o); end
        rst_n = 1'b0;
        #1;
        checks++; if ({ram.rd_en_o, ram.rd_addr_o, sdo_o, sclk_o, le_o, busy_o, frame_done_o, overrun_o} !== '0) begin errors++; $display("FAIL async_reset: got addr=%0d sdo=%b busy=%b ovr=%b expected all 0", ram.rd_addr_o, sdo_o, busy_o, overrun_o); end
        clear_stats();
        run_cycles(8);
        checks++; if (n_le_cyc !== 0 || n_done !== 0) begin errors++; $display("FAIL reset_no_latch: got le=%0d done=%0d expected 0/0", n_le_cyc, n_done); end
        rst_n = 1'b1;
        run_cycles(2);
        start_frame();
        run_cycles(40);
        checks++; if (first_rd_cyc !== 1 || n_rd !== 2 || addr_err !== 0) begin errors++; $display("FAIL restart_addr0: got first=%0d reads=%0d bad=%0d expected 1/2/0", first_rd_cyc, n_rd, addr_err); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL restart_overrun: got %b expected 0", overrun_o); end
        sdbp_flag = 1'b0;
        rst_n = 1'b0;
        run_cycles(2);
        rst_n = 1'b1;
        run_cycles(2);
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        mem_mode = 1;
        start_frame();
        run_cycles(29);
        sdbp_flag = 1'b0;
        run_until_done(12400);
        for (int a = 0; a < NUM_LEDS; a++) if (capt[a] !== 16'hFFFF) bad++;
        checks++; if (bad !== 0 || word_n !== 360) begin errors++; $display("FAIL ones_frame: got bad=%0d words=%0d expected 0/360", bad, word_n); end
        checks++; if (period_err !== 0 || hold_err !== 0 || n_done !== 1) begin errors++; $display("FAIL ones_timing: got period_err=%0d hold_err=%0d done=%0d expected 0/0/1", period_err, hold_err, n_done); end
        mem_mode = 2;
        start_frame();
        run_cycles(29);
        sdbp_flag = 1'b0;
        run_until_done(12400);
        bad = 0;
        for (int a = 0; a < NUM_LEDS; a++) if (capt[a] !== 16'h0000) bad++;
        checks++; if (bad !== 0 || n_sdo_hi !== 0) begin errors++; $display("FAIL zeros_frame: got bad=%0d sdo_high_cycles=%0d expected 0/0", bad, n_sdo_hi); end
        checks++; if (first_rd_cyc !== 1 || n_rise !== 5760 || n_done !== 1) begin errors++; $display("FAIL zeros_counts: got first=%0d rises=%0d done=%0d expected 1/5760/1", first_rd_cyc, n_rise, n_done); end
        checks++; if (period_err !== 0 || le_first_cyc !== 12241) begin errors++; $display("FAIL zeros_timing: got period_err=%0d le_at=%0d expected 0/12241", period_err, le_first_cyc); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overrun();
        test_held_flag();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
